// File: rtl/disp_pkg.sv
// Shared definitions for the disp nibble display path.
//   NIB_W      : width of one display nibble
//   rx_state_e : receiver framing state (HUNT waits for sync, COLLECT gathers nibbles)
//   is_bcd()   : true when a nibble is a legal decimal digit (0..9)
package disp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } rx_state_e;

    function automatic logic is_bcd(input logic [NIB_W-1:0] nib);
        return (nib <= 4'd9);
    endfunction

endpackage

// File: rtl/disp_rx_lock.sv
// Saturating good-frame counter that drives the receiver lock status.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   good_word   : one-cycle pulse for each cleanly completed frame
//   bad_event   : one-cycle pulse for any framing/content violation (clears count)
//   locked      : high while the count has reached LOCK_WORDS
module disp_rx_lock #(
    parameter int LOCK_WORDS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic good_word,
    input  logic bad_event,
    output logic locked
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_WORDS);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // A violation wins over a good word arriving in the same cycle.
        if (bad_event) begin
            cnt_d = '0;
        end else if (good_word && (cnt_q != LOCK_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign locked = (cnt_q == LOCK_MAX);

endmodule

// File: rtl/disp_rx.sv
// Receiver for the disp nibble display serializer: reassembles MSN-first
// nibble frames delimited by sync into NIBBLES*4-bit words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   display_in  : nibble stream from disp display_out
//   sync        : high with the most significant nibble of each frame
//   word_out    : last complete word (held between frames)
//   word_valid  : one-cycle pulse when word_out updates
//   locked      : LOCK_WORDS consecutive good frames seen
//   frame_err   : one-cycle pulse when sync interrupts a partial frame
//   bcd_err     : (DISP_RX_BCD_CHECK_EN only) pulses with word_valid when the
//                 delivered frame contained a nibble above 9
// Build option: define DISP_RX_BCD_CHECK_EN to enable the decimal-digit check.
module disp_rx
    import disp_pkg::*;
#(
    parameter int NIBBLES    = 4,
    parameter int LOCK_WORDS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NIB_W-1:0]         display_in,
    input  logic                     sync,
    output logic [NIB_W*NIBBLES-1:0] word_out,
    output logic                     word_valid,
    output logic                     locked,
    output logic                     frame_err
`ifdef DISP_RX_BCD_CHECK_EN
    ,
    output logic                     bcd_err
`endif
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    rx_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sh_q, sh_d;
    logic [W-1:0]     word_q, word_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [W-1:0]     shifted;
    logic             done;
    logic             bad_event;
    logic             good_word;

    assign shifted = (sh_q << NIB_W) | W'(display_in);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        word_d  = word_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        done    = 1'b0;
        bad_event = 1'b0;

        case (state_q)
            HUNT: begin
                if (sync) begin
                    sh_d  = W'(display_in);
                    idx_d = IDX_W'(1);
                    if (NIBBLES == 1) begin
                        done = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (sync) begin
                    // Premature sync: drop the partial word and restart on this nibble.
                    err_d     = 1'b1;
                    bad_event = 1'b1;
                    sh_d      = W'(display_in);
                    idx_d     = IDX_W'(1);
                end else begin
                    sh_d  = shifted;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        done    = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (done) begin
            word_d  = sh_d;
            valid_d = 1'b1;
            idx_d   = '0;
        end
    end

`ifdef DISP_RX_BCD_CHECK_EN
    // Sticky per-frame flag: restarts with each sync, accumulates otherwise.
    logic bcd_flag_q, bcd_flag_d;
    logic bcd_err_q, bcd_err_d;
    logic nib_bad;

    assign nib_bad = !is_bcd(display_in);

    always_comb begin
        bcd_flag_d = bcd_flag_q;
        if (sync) begin
            bcd_flag_d = nib_bad;
        end else if (state_q == COLLECT) begin
            bcd_flag_d = bcd_flag_q | nib_bad;
        end
        bcd_err_d = done & bcd_flag_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_flag_q <= 1'b0;
            bcd_err_q  <= 1'b0;
        end else begin
            bcd_flag_q <= bcd_flag_d;
            bcd_err_q  <= bcd_err_d;
        end
    end

    assign bcd_err   = bcd_err_q;
    assign good_word = done & ~bcd_flag_d;
    logic lock_bad;
    assign lock_bad  = bad_event | bcd_err_d;
`else
    assign good_word = done;
    logic lock_bad;
    assign lock_bad  = bad_event;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
            idx_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    disp_rx_lock #(
        .LOCK_WORDS(LOCK_WORDS)
    ) u_lock (
        .clk       (clk),
        .reset     (reset),
        .good_word (good_word),
        .bad_event (lock_bad),
        .locked    (locked)
    );

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_disp_rx.sv
// Self-checking bench for disp_rx: directed scenarios followed by random
// sync/nibble traffic, all compared every cycle against a queue-based model.
module tb_disp_rx;

    localparam int N    = 4;
    localparam int LOCK = 2;
`ifdef DISP_RX_BCD_CHECK_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync = 1'b0;
    logic [3:0]  display_in = 4'd0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        locked;
    logic        frame_err;
`ifdef DISP_RX_BCD_CHECK_EN
    logic        bcd_err;
`endif

    always #5 clk = ~clk;

    disp_rx #(.NIBBLES(N), .LOCK_WORDS(LOCK)) dut (
        .clk        (clk),
        .reset      (reset),
        .display_in (display_in),
        .sync       (sync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .frame_err  (frame_err)
`ifdef DISP_RX_BCD_CHECK_EN
        ,
        .bcd_err    (bcd_err)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the nibbles of the frame in progress (empty = hunting),
    // the number of consecutive good frames, and the expected registered outputs.
    int unsigned cur[$];
    int          good_cnt = 0;
    logic [15:0] m_word = '0;
    bit          m_valid = 0;
    bit          m_err = 0;
    bit          m_bcd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit s, input int unsigned nib);
        int unsigned w;
        bit any_bad;
        m_valid = 0;
        m_err   = 0;
        m_bcd   = 0;
        if (rst) begin
            cur.delete();
            good_cnt = 0;
            m_word   = '0;
            return;
        end
        if (s) begin
            if (cur.size() != 0) begin
                m_err    = 1;
                good_cnt = 0;
            end
            cur.delete();
            cur.push_back(nib);
        end else if (cur.size() != 0) begin
            cur.push_back(nib);
        end
        if (cur.size() == N) begin
            w = 0;
            any_bad = 0;
            foreach (cur[i]) begin
                w = w * 16 + cur[i];
                if (cur[i] > 9) any_bad = 1;
            end
            m_word  = w[15:0];
            m_valid = 1;
            if (BCD_ON && any_bad) begin
                m_bcd    = 1;
                good_cnt = 0;
            end else if (good_cnt < LOCK) begin
                good_cnt++;
            end
            cur.delete();
        end
    endtask

    // Drive one cycle, advance the model on the same edge, compare after it.
    task automatic cyc(input bit rst, input bit s, input int unsigned nib, input string tag);
        reset      = rst;
        sync       = s;
        display_in = nib[3:0];
        @(posedge clk);
        model_step(rst, s, nib);
        #1;
        check({tag, "/word_out"},   32'(word_out),   32'(m_word));
        check({tag, "/word_valid"}, 32'(word_valid), 32'(m_valid));
        check({tag, "/locked"},     32'(locked),     32'(good_cnt == LOCK));
        check({tag, "/frame_err"},  32'(frame_err),  32'(m_err));
`ifdef DISP_RX_BCD_CHECK_EN
        check({tag, "/bcd_err"},    32'(bcd_err),    32'(m_bcd));
`endif
    endtask

    task automatic frame(input logic [15:0] w, input string tag);
        cyc(0, 1, w[15:12], tag);
        cyc(0, 0, w[11:8],  tag);
        cyc(0, 0, w[7:4],   tag);
        cyc(0, 0, w[3:0],   tag);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, "reset");
        check("reset_word", 32'(word_out), 32'h0);

        // Single frame 1234
        frame(16'h1234, "f1234");
        check("f1234_word", 32'(word_out), 32'h1234);
        check("f1234_valid", 32'(word_valid), 32'h1);
        check("f1234_locked", 32'(locked), 32'h0);
        cyc(0, 0, 0, "f1234_gap");

        // Back-to-back 5678 then 1234, lock on second pulse
        cyc(1, 0, 0, "b2b_rst");
        frame(16'h5678, "b2b_a");
        check("b2b_a_word", 32'(word_out), 32'h5678);
        frame(16'h1234, "b2b_b");
        check("b2b_b_word", 32'(word_out), 32'h1234);
        check("b2b_locked", 32'(locked), 32'h1);
        cyc(0, 0, 0, "b2b_gap");

        // Early sync: 5,6 then a fresh 1234
        cyc(1, 0, 0, "early_rst");
        cyc(0, 1, 5, "early");
        cyc(0, 0, 6, "early");
        cyc(0, 1, 1, "early_sync");
        check("early_err", 32'(frame_err), 32'h1);
        check("early_locked", 32'(locked), 32'h0);
        cyc(0, 0, 2, "early");
        check("early_err_pulse", 32'(frame_err), 32'h0);
        cyc(0, 0, 3, "early");
        cyc(0, 0, 4, "early");
        check("early_word", 32'(word_out), 32'h1234);
        cyc(0, 0, 0, "early_gap");

        // Noise while hunting
        repeat (3) cyc(0, 0, 7, "noise");
        frame(16'h1234, "noise_f");
        check("noise_word", 32'(word_out), 32'h1234);

        // Reset mid-frame
        cyc(0, 1, 1, "midrst");
        cyc(0, 0, 2, "midrst");
        cyc(1, 0, 0, "midrst_rst");
        check("midrst_word", 32'(word_out), 32'h0);
        check("midrst_err", 32'(frame_err), 32'h0);
        frame(16'hABCD, "abcd");
        check("abcd_word", 32'(word_out), 32'hABCD);

        // Lock up with decimal frames, then a frame holding an A nibble
        cyc(1, 0, 0, "bcd_rst");
        frame(16'h1111, "bcd_pre");
        frame(16'h2222, "bcd_pre");
        frame(16'h12A4, "bcd");
        check("bcd_word", 32'(word_out), 32'h12A4);
        check("bcd_valid", 32'(word_valid), 32'h1);
        cyc(0, 0, 0, "bcd_gap");

        // Random traffic: frequent syncs exercise early-sync and back-to-back paths
        for (int i = 0; i < 800; i++) begin
            bit rst;
            bit s;
            rst = ($urandom_range(0, 149) == 0);
            s   = ($urandom_range(0, 4) == 0);
            cyc(rst, s, $urandom_range(0, 15), "rand");
        end
        // A run of clean back-to-back frames so lock is reached under random data
        for (int i = 0; i < 6; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            frame(w, "rand_b2b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
